// File: rtl/axi_lite_master_if.sv
// axi_lite_master_if
// ------------------
// Bundles every non-clock signal of the AXI4-Lite initiator into one interface.
// The master modport is the initiator's view and the slave modport is the
// view of whatever sits around it (user logic plus AXI responder).
//
// Port summary (master view):
//   cmd_*        in : single-word command from user logic (cmd_ready is an output)
//   rsp_*        out: completion status / read data (rsp_ready is an input)
//   write_addr*  out: AW channel (write_addr_ready in)
//   write_data*  out: W channel (write_data_ready in)
//   write_resp*  in : B channel (write_resp_ready out)
//   read_addr*   out: AR channel (read_addr_ready in)
//   read_data*   in : R channel with read_resp (read_data_ready out)
interface axi_lite_master_if #(
  parameter int ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [1:0]        rsp_resp;
  logic [31:0]       rsp_rdata;

  logic [ADDR_W-1:0] write_addr;
  logic              write_addr_valid;
  logic              write_addr_ready;

  logic [31:0]       write_data;
  logic              write_data_valid;
  logic              write_data_ready;

  logic [1:0]        write_resp;
  logic              write_resp_valid;
  logic              write_resp_ready;

  logic [ADDR_W-1:0] read_addr;
  logic              read_addr_valid;
  logic              read_addr_ready;

  logic [31:0]       read_data;
  logic              read_data_valid;
  logic              read_data_ready;
  logic [1:0]        read_resp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_resp, rsp_rdata,
    input  rsp_ready,
    output write_addr, write_addr_valid,
    input  write_addr_ready,
    output write_data, write_data_valid,
    input  write_data_ready,
    input  write_resp, write_resp_valid,
    output write_resp_ready,
    output read_addr, read_addr_valid,
    input  read_addr_ready,
    input  read_data, read_data_valid, read_resp,
    output read_data_ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_resp, rsp_rdata,
    output rsp_ready,
    input  write_addr, write_addr_valid,
    output write_addr_ready,
    input  write_data, write_data_valid,
    output write_data_ready,
    output write_resp, write_resp_valid,
    input  write_resp_ready,
    input  read_addr, read_addr_valid,
    output read_addr_ready,
    output read_data, read_data_valid, read_resp,
    input  read_data_ready
  );
endinterface

// File: rtl/axi_lite_master.sv
// axi_lite_master
// ---------------
// AXI4-Lite initiator: accepts one single-word command at a time from user
// logic, runs it as an AXI4-Lite write or read, and hands back the response
// code (plus read data) on a valid/ready completion port. Only one command is
// ever in flight. There is no timeout: a responder that never answers keeps
// the FSM waiting forever.
//
// Ports:
//   axi_clk  in : single clock for all logic
//   rstn     in : asynchronous active-low reset (release synchronised externally)
//   bus      -- : axi_lite_master_if.master (command, completion, AW/W/B/AR/R)
//
// Every output is registered except cmd_ready, which is decoded from IDLE.
module axi_lite_master #(
  parameter int ADDR_W = 2
) (
  input logic               axi_clk,
  input logic               rstn,
  axi_lite_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_e;

  state_e            state_q,     state_d;

  logic [ADDR_W-1:0] waddr_q,     waddr_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic              awvalid_q,   awvalid_d;
  logic              wvalid_q,    wvalid_d;
  logic              bready_q,    bready_d;
  logic              aw_done_q,   aw_done_d;
  logic              w_done_q,    w_done_d;

  logic [ADDR_W-1:0] raddr_q,     raddr_d;
  logic              arvalid_q,   arvalid_d;
  logic              rready_q,    rready_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [1:0]        rsp_resp_q,  rsp_resp_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;

  // A handshake is our registered valid/ready meeting the responder's signal
  // in the same cycle; it takes effect on the next clock edge.
  assign aw_hs = awvalid_q & bus.write_addr_ready;
  assign w_hs  = wvalid_q  & bus.write_data_ready;
  assign b_hs  = bready_q  & bus.write_resp_valid;
  assign ar_hs = arvalid_q & bus.read_addr_ready;
  assign r_hs  = rready_q  & bus.read_data_valid;

  // State and output registers. Reset clears every AXI valid/ready and all
  // payloads immediately, even in the middle of a transaction.
  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      raddr_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      raddr_q     <= raddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state and next-output logic. Everything holds by default, which is
  // what keeps valids and payloads stable until their handshake.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    raddr_d     = raddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_write) begin
            waddr_d   = bus.cmd_addr;
            wdata_d   = bus.cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_REQ;
          end else begin
            raddr_d   = bus.cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        // AW and W complete independently; a skewed pair costs the larger
        // of the two stalls. The done flags fold in this cycle's handshakes
        // so that simultaneous completion also moves on at once.
        if (aw_hs) begin
          awvalid_d = 1'b0;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
        end
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q  | w_hs;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        // A B response raised early simply waits here until bready is up.
        if (b_hs) begin
          rsp_resp_d  = bus.write_resp;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      RD_REQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end

      RD_RESP: begin
        if (r_hs) begin
          rsp_rdata_d = bus.read_data;
          rsp_resp_d  = bus.read_resp;
          rsp_write_d = 1'b0;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        // The completion stays up, unchanged, until the user takes it.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready        = (state_q == IDLE);

  assign bus.write_addr       = waddr_q;
  assign bus.write_addr_valid = awvalid_q;
  assign bus.write_data       = wdata_q;
  assign bus.write_data_valid = wvalid_q;
  assign bus.write_resp_ready = bready_q;

  assign bus.read_addr        = raddr_q;
  assign bus.read_addr_valid  = arvalid_q;
  assign bus.read_data_ready  = rready_q;

  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_write        = rsp_write_q;
  assign bus.rsp_resp         = rsp_resp_q;
  assign bus.rsp_rdata        = rsp_rdata_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master
// ------------------
// Bench for axi_lite_master. A reactive AXI4-Lite register responder with
// configurable wait states and response codes sits on the AXI side. Commands
// are issued by applyStimulus, which computes the expected completion from a
// word-addressed memory model and queues it; an independent monitor compares
// every presented completion against the head of that queue.
module tb_axi_lite_master;

  localparam int ADDR_W = 2;
  localparam int LIMIT  = 300;

  typedef struct {
    logic        w;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } rsp_t;

  logic axi_clk = 1'b0;
  logic rstn    = 1'b1;
  int   cyc     = 0;

  int checkCount = 0;
  int passCount  = 0;

  rsp_t        expQ[$];
  logic [31:0] modelMem [4];
  logic [31:0] slaveMem [4];

  // Responder configuration for the transaction currently being issued
  int               awWait = 0, wWait = 0, bWait = 0, arWait = 0, rWait = 0;
  bit               earlyB = 1'b0;
  logic [1:0]       planResp = 2'b00;
  logic [ADDR_W-1:0] curAddr = '0;
  logic [31:0]      curWdata = '0;

  // Responder internal state
  bit               awHs, wHs, bHs, arHs, rHs;
  bit               gotAw = 1'b0, gotW = 1'b0, bBusy = 1'b0, arGot = 1'b0;
  int               awCnt = 0, wCnt = 0, arCnt = 0, bCnt = 0, rCnt = 0;
  logic [ADDR_W-1:0] capAddr = '0, capRaddr = '0;
  logic [31:0]      capData = '0;

  // Per-transaction measurements
  int awValidCycles = 0, wValidCycles = 0, bReadyCycles = 0, stallCount = 0;
  int acceptEdge = 0, rspCyc = 0;
  bit rspSeen = 1'b0;

  // Completion-port acceptance control
  int holdLow     = 0;
  bit randomReady = 1'b0;

  axi_lite_master_if #(.ADDR_W(ADDR_W)) bus ();

  axi_lite_master #(.ADDR_W(ADDR_W)) dut (
    .axi_clk (axi_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  always #5 axi_clk = ~axi_clk;

  always @(posedge axi_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    checkOutput({tag, "_axi_ctrl"}, 32'({bus.write_addr_valid, bus.write_data_valid,
                bus.write_resp_ready, bus.read_addr_valid, bus.read_data_ready}), 32'd0);
    checkOutput({tag, "_rsp_ctrl"}, 32'({bus.rsp_valid, bus.rsp_write, bus.rsp_resp}), 32'd0);
    checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    checkOutput({tag, "_addrs"}, 32'({bus.write_addr, bus.read_addr}), 32'd0);
    checkOutput({tag, "_wdata"}, bus.write_data, 32'd0);
  endtask

  // Waits until every queued completion has been taken and the DUT is idle.
  task automatic waitDrain(input string tag);
    int guard;
    guard = 0;
    do begin
      @(negedge axi_clk);
      guard++;
    end while (!(expQ.size() == 0 && bus.cmd_ready) && guard < LIMIT);
    if (guard >= LIMIT) begin
      checkOutput({tag, "_drain_timeout"}, 32'(expQ.size()), 32'd0);
    end
  endtask

  // Issues one command: configures the responder, predicts the completion
  // from the memory model, queues it, then holds cmd_valid until accepted.
  task automatic applyStimulus(input bit w, input logic [ADDR_W-1:0] a,
                               input logic [31:0] d, input logic [1:0] resp,
                               input int aww, input int ww, input int bw,
                               input int arw, input int rw, input bit early);
    rsp_t e;
    int   guard;
    guard = 0;
    // The responder is free once the DUT is idle or holding a completion.
    @(negedge axi_clk);
    while (!(bus.cmd_ready || bus.rsp_valid) && guard < LIMIT) begin
      @(negedge axi_clk);
      guard++;
    end
    if (guard >= LIMIT) checkOutput("prev_txn_timeout", 32'd1, 32'd0);
    awWait = aww; wWait = ww; bWait = bw; arWait = arw; rWait = rw;
    earlyB = early; planResp = resp; curAddr = a; curWdata = d;
    e.w = w;
    e.resp = resp;
    if (w) begin
      e.rdata = 32'd0;
      if (resp == 2'b00) modelMem[a] = d;
    end else begin
      e.rdata = modelMem[a];
    end
    expQ.push_back(e);
    awValidCycles = 0; wValidCycles = 0; bReadyCycles = 0; rspSeen = 1'b0;

    @(posedge axi_clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = w ? d : $urandom;
    guard = 0;
    forever begin
      @(negedge axi_clk);
      if (bus.cmd_ready) begin
        acceptEdge = cyc + 1;
        break;
      end
      guard++;
      if (guard >= LIMIT) begin
        checkOutput("cmd_accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge axi_clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = ADDR_W'($urandom_range(0, 3));
    bus.cmd_wdata = $urandom;
  endtask

  // AXI responder: samples handshakes and protocol at the falling edge, then
  // updates its outputs just after the rising edge.
  initial begin
    bus.write_addr_ready = 1'b0;
    bus.write_data_ready = 1'b0;
    bus.write_resp       = 2'b00;
    bus.write_resp_valid = 1'b0;
    bus.read_addr_ready  = 1'b0;
    bus.read_data        = 32'd0;
    bus.read_data_valid  = 1'b0;
    bus.read_resp        = 2'b00;
    forever begin
      @(negedge axi_clk);
      awHs = 1'b0; wHs = 1'b0; bHs = 1'b0; arHs = 1'b0; rHs = 1'b0;
      if (rstn) begin
        awHs = bus.write_addr_valid & bus.write_addr_ready;
        wHs  = bus.write_data_valid & bus.write_data_ready;
        bHs  = bus.write_resp_valid & bus.write_resp_ready;
        arHs = bus.read_addr_valid  & bus.read_addr_ready;
        rHs  = bus.read_data_valid  & bus.read_data_ready;
        if (bus.write_addr_valid) begin
          awValidCycles++;
          checkOutput("aw_payload", 32'(bus.write_addr), 32'(curAddr));
        end
        if (bus.write_data_valid) begin
          wValidCycles++;
          checkOutput("w_payload", bus.write_data, curWdata);
        end
        if (bus.read_addr_valid) begin
          checkOutput("ar_payload", 32'(bus.read_addr), 32'(curAddr));
        end
        if (bus.write_resp_ready) begin
          bReadyCycles++;
          checkOutput("bready_before_aw_w", 32'(gotAw && gotW), 32'd1);
        end
        if (bus.read_data_ready) begin
          checkOutput("rready_before_ar", 32'(arGot), 32'd1);
        end
        if (bus.rsp_valid) begin
          checkOutput("quiet_while_rsp", 32'({bus.cmd_ready, bus.write_addr_valid,
                      bus.write_data_valid, bus.read_addr_valid, bus.write_resp_ready,
                      bus.read_data_ready}), 32'd0);
        end
        if (awHs) capAddr  = bus.write_addr;
        if (wHs)  capData  = bus.write_data;
        if (arHs) capRaddr = bus.read_addr;
      end

      @(posedge axi_clk); #1;
      if (!rstn) begin
        bus.write_addr_ready = 1'b0;
        bus.write_data_ready = 1'b0;
        bus.write_resp_valid = 1'b0;
        bus.read_addr_ready  = 1'b0;
        bus.read_data_valid  = 1'b0;
        gotAw = 1'b0; gotW = 1'b0; bBusy = 1'b0; arGot = 1'b0;
        awCnt = 0; wCnt = 0; arCnt = 0; bCnt = 0; rCnt = 0;
      end else begin
        if (awHs) gotAw = 1'b1;
        if (wHs)  gotW  = 1'b1;
        if (arHs) begin
          arGot = 1'b1;
          rCnt  = 0;
        end
        if (gotAw && gotW && !bBusy) begin
          bBusy = 1'b1;
          bCnt  = 0;
          if (planResp == 2'b00) slaveMem[capAddr] = capData;
        end

        if (bHs) begin
          bus.write_resp_valid = 1'b0;
          bBusy = 1'b0; gotAw = 1'b0; gotW = 1'b0;
        end else if (earlyB && !bus.write_resp_valid && !gotW &&
                     (gotAw || bus.write_addr_valid || bus.write_data_valid)) begin
          bus.write_resp_valid = 1'b1;
          bus.write_resp       = planResp;
        end else if (bBusy && !bus.write_resp_valid) begin
          if (bCnt >= bWait) begin
            bus.write_resp_valid = 1'b1;
            bus.write_resp       = planResp;
          end else begin
            bCnt++;
          end
        end

        if (rHs) begin
          bus.read_data_valid = 1'b0;
          arGot = 1'b0;
        end else if (arGot && !bus.read_data_valid) begin
          if (rCnt >= rWait) begin
            bus.read_data_valid = 1'b1;
            bus.read_data       = slaveMem[capRaddr];
            bus.read_resp       = planResp;
          end else begin
            rCnt++;
          end
        end

        if (bus.write_addr_valid) begin
          bus.write_addr_ready = (awCnt >= awWait);
          awCnt++;
        end else begin
          bus.write_addr_ready = 1'b0;
          awCnt = 0;
        end
        if (bus.write_data_valid) begin
          bus.write_data_ready = (wCnt >= wWait);
          wCnt++;
        end else begin
          bus.write_data_ready = 1'b0;
          wCnt = 0;
        end
        if (bus.read_addr_valid) begin
          bus.read_addr_ready = (arCnt >= arWait);
          arCnt++;
        end else begin
          bus.read_addr_ready = 1'b0;
          arCnt = 0;
        end
      end
    end
  end

  // Completion acceptance: an optional forced hold, otherwise ready or random.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge axi_clk); #1;
      if (holdLow > 0) begin
        bus.rsp_ready = 1'b0;
        if (bus.rsp_valid) holdLow--;
      end else begin
        bus.rsp_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Scoreboard monitor: every presented completion must match the queue head;
  // it is popped only when the user side accepts it.
  initial begin
    forever begin
      @(negedge axi_clk);
      if (rstn && bus.rsp_valid) begin
        if (!rspSeen) begin
          rspSeen = 1'b1;
          rspCyc  = cyc;
        end
        if (!bus.rsp_ready) stallCount++;
        if (expQ.size() == 0) begin
          checkOutput("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          checkOutput("rsp_write", 32'(bus.rsp_write), 32'(expQ[0].w));
          checkOutput("rsp_resp",  32'(bus.rsp_resp),  32'(expQ[0].resp));
          checkOutput("rsp_rdata", bus.rsp_rdata,      expQ[0].rdata);
          if (bus.rsp_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    bit          w;
    logic [31:0] d;
    int          guard;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      modelMem[i] = 32'd0;
      slaveMem[i] = 32'd0;
    end

    // Power-on reset
    #3 rstn = 1'b0;
    #1 checkResetState("por_async");
    #19 checkResetState("por");
    @(posedge axi_clk); #3 rstn = 1'b1;

    // Zero-wait write: single-cycle AW/W/B and a two-cycle completion latency
    waitDrain("pre_wr");
    applyStimulus(1'b1, 2'd1, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 0, 1'b0);
    waitDrain("wr");
    checkOutput("wr_aw_cycles", 32'(awValidCycles), 32'd1);
    checkOutput("wr_w_cycles",  32'(wValidCycles),  32'd1);
    checkOutput("wr_b_cycles",  32'(bReadyCycles),  32'd1);
    checkOutput("wr_latency",   32'(rspCyc - acceptEdge), 32'd2);

    // Skewed write: W ready three cycles late, AW immediate
    applyStimulus(1'b1, 2'd2, 32'hA5A5_0F0F, 2'b00, 0, 3, 0, 0, 0, 1'b0);
    waitDrain("skew");
    checkOutput("skew_aw_cycles", 32'(awValidCycles), 32'd1);
    checkOutput("skew_w_cycles",  32'(wValidCycles),  32'd4);
    checkOutput("skew_b_cycles",  32'(bReadyCycles),  32'd1);
    checkOutput("skew_latency",   32'(rspCyc - acceptEdge), 32'd5);

    // Read with SLVERR after two wait cycles
    applyStimulus(1'b1, 2'd3, 32'h12345678, 2'b00, 0, 0, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 2'd3, 32'd0, 2'b10, 0, 0, 0, 0, 2, 1'b0);
    waitDrain("rd_err");
    checkOutput("rd_err_latency", 32'(rspCyc - acceptEdge), 32'd4);

    // Completion backpressure with the next command already waiting
    stallCount = 0;
    holdLow = 5;
    applyStimulus(1'b1, 2'd0, 32'hCAFE_F00D, 2'b00, 0, 0, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 2'd0, 32'd0, 2'b00, 0, 0, 0, 0, 0, 1'b0);
    waitDrain("bp");
    checkOutput("bp_stall_cycles", 32'(stallCount), 32'd5);

    // Early B response (DECERR) raised before the W handshake
    applyStimulus(1'b1, 2'd1, 32'h0BAD_BEEF, 2'b11, 0, 2, 0, 0, 0, 1'b1);
    waitDrain("early_b");
    checkOutput("early_b_latency", 32'(rspCyc - acceptEdge), 32'd4);

    // Randomised traffic
    randomReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      applyStimulus(w, ADDR_W'($urandom_range(0, 3)), d,
                    2'($urandom_range(0, 3)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    w ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    waitDrain("random");
    randomReady = 1'b0;

    // Reset in the middle of a read while read_data_ready is high
    applyStimulus(1'b0, 2'd2, 32'd0, 2'b00, 0, 0, 0, 0, 6, 1'b0);
    guard = 0;
    while (!bus.read_data_ready && guard < LIMIT) begin
      @(negedge axi_clk);
      guard++;
    end
    if (guard >= LIMIT) checkOutput("rready_wait_timeout", 32'd1, 32'd0);
    #2 rstn = 1'b0;
    expQ.delete();
    #1 checkResetState("mid_read");
    @(posedge axi_clk); #3 rstn = 1'b1;
    #1 checkOutput("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Normal operation after the abort
    applyStimulus(1'b1, 2'd2, 32'h5555_AAAA, 2'b00, 1, 0, 1, 0, 0, 1'b0);
    applyStimulus(1'b0, 2'd2, 32'd0, 2'b00, 0, 0, 0, 1, 1, 1'b0);
    waitDrain("recover");

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
